// File: rtl/trim_gen.sv
// trim_gen: sweeps a 12-bit bandgap trim code from 0 to 4095. Each code is
// shifted MSB-first onto DOUT under a gated serial clock ENCLK, and the block
// then holds for a settling interval before moving to the next code.
module trim_gen #(
    parameter int DIV    = 25,    // ENCLK half-period in CLK50 cycles
    parameter int SETTLE = 5000   // hold cycles after each 12-bit frame
) (
    input  logic        CLK50,
    input  logic        RST,
    input  logic        START,
    output logic        ENCLK,
    output logic        DOUT,
    output logic [11:0] TRIM_CODE
);

    localparam int DW = $clog2(2 * DIV);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        st_idle,
        st_load,
        st_shift,
        st_settle,
        st_done
    } state_t;

    state_t        state;
    logic [11:0]   shreg;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] set_cnt;

    // DOUT comes straight from the MSB flop of the shift register. The
    // register is cleared whenever the line must idle low.
    assign DOUT = shreg[11];

    // Sweep sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state     <= st_idle;
            TRIM_CODE <= '0;
            ENCLK     <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            set_cnt   <= '0;
        end else begin
            case (state)
                st_idle: begin
                    TRIM_CODE <= '0;
                    ENCLK     <= 1'b0;
                    shreg     <= '0;
                    if (START) begin
                        state <= st_load;
                    end
                end

                st_load: begin
                    if (!START) begin
                        state     <= st_idle;
                        TRIM_CODE <= '0;
                        ENCLK     <= 1'b0;
                        shreg     <= '0;
                    end else begin
                        shreg   <= TRIM_CODE;
                        ENCLK   <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= st_shift;
                    end
                end

                st_shift: begin
                    if (!START) begin
                        state     <= st_idle;
                        TRIM_CODE <= '0;
                        ENCLK     <= 1'b0;
                        shreg     <= '0;
                    end else if (div_cnt == DW'(DIV - 1)) begin
                        // mid-slot: receiver samples DOUT on this rising edge
                        ENCLK   <= 1'b1;
                        div_cnt <= div_cnt + DW'(1);
                    end else if (div_cnt == DW'(2 * DIV - 1)) begin
                        // slot end: ENCLK falls together with the data change
                        ENCLK   <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == 4'd11) begin
                            shreg   <= '0;
                            set_cnt <= '0;
                            state   <= st_settle;
                        end else begin
                            shreg   <= {shreg[10:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                st_settle: begin
                    ENCLK <= 1'b0;
                    shreg <= '0;
                    if (!START) begin
                        state     <= st_idle;
                        TRIM_CODE <= '0;
                    end else if (set_cnt == SW'(SETTLE - 1)) begin
                        if (TRIM_CODE == 12'hFFF) begin
                            state <= st_done;
                        end else begin
                            TRIM_CODE <= TRIM_CODE + 12'd1;
                            state     <= st_load;
                        end
                    end else begin
                        TRIM_CODE <= TRIM_CODE;
                        set_cnt   <= set_cnt + SW'(1);
                    end
                end

                st_done: begin
                    ENCLK <= 1'b0;
                    shreg <= '0;
                    if (!START) begin
                        state     <= st_idle;
                        TRIM_CODE <= '0;
                    end
                end

                default: begin
                    state     <= st_idle;
                    TRIM_CODE <= '0;
                    ENCLK     <= 1'b0;
                    shreg     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trim_gen.sv
// tb_trim_gen: scoreboard bench for trim_gen with DIV=2, SETTLE=4 (53-cycle frames).
// Expected serial bits are queued when a frame is started and popped on every
// ENCLK rising edge seen by the monitor.
module tb_trim_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        enclk;
    logic        dout;
    logic [11:0] trim_code;

    int total = 0;
    int bad   = 0;

    logic exp_q[$];
    int   rise_q[$];
    int   cyc = 0;
    logic enclk_prev = 1'b0;
    logic exp_b;

    always #5 clk = ~clk;

    trim_gen #(.DIV(2), .SETTLE(4)) dut (
        .CLK50(clk),
        .RST(rst),
        .START(start),
        .ENCLK(enclk),
        .DOUT(dout),
        .TRIM_CODE(trim_code)
    );

    // Scoreboard monitor: every ENCLK rise must match the next queued bit.
    always @(negedge clk) begin
        cyc++;
        if (enclk === 1'b1 && enclk_prev !== 1'b1) begin
            rise_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL enclk_rise: unexpected rising edge at cycle %0d trim_code=%0d", cyc, trim_code);
            end else begin
                exp_b = exp_q.pop_front();
                if (dout !== exp_b) begin
                    bad++;
                    $display("FAIL dout_bit: trim_code=%0d got %b want %b at cycle %0d", trim_code, dout, exp_b, cyc);
                end
            end
        end
        enclk_prev = enclk;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_code(input logic [11:0] c, input int nbits);
        for (int i = 11; i > 11 - nbits; i--) exp_q.push_back(c[i]);
    endtask

    task automatic test_reset;
        int viol;
        rst = 1'b1;
        start = 1'b0;
        cycles(3);
        total++; if (enclk !== 1'b0) begin bad++; $display("FAIL reset_enclk: got %b want 0", enclk); end
        total++; if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout: got %b want 0", dout); end
        total++; if (trim_code !== 12'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", trim_code); end
        rst = 1'b0;
        viol = 0;
        repeat (100) begin
            cycles(1);
            if (enclk !== 1'b0 || dout !== 1'b0 || trim_code !== 12'd0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL idle_quiet: %0d non-idle cycles, want 0", viol); end
    endtask

    task automatic test_first_frame;
        int viol;
        int per_bad;
        exp_q.delete();
        rise_q.delete();
        push_code(12'd0, 12);
        push_code(12'd1, 12);
        start = 1'b1;
        viol = 0;
        repeat (53) begin
            cycles(1);
            if (trim_code !== 12'd0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL code0_hold: %0d cycles off 0, want 0", viol); end
        total++; if (rise_q.size() != 12) begin bad++; $display("FAIL rise_count: got %0d want 12", rise_q.size()); end
        per_bad = 0;
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 4) per_bad++;
        total++; if (per_bad != 0) begin bad++; $display("FAIL enclk_period: %0d periods not 4 cycles", per_bad); end
        cycles(1);
        total++; if (trim_code !== 12'd1) begin bad++; $display("FAIL code_step: got %0d want 1", trim_code); end
        cycles(48);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frame1_bits: %0d bits not seen, want 0", exp_q.size()); end
        start = 1'b0;
        cycles(2);
        total++; if (trim_code !== 12'd0) begin bad++; $display("FAIL stop_code: got %0d want 0", trim_code); end
    endtask

    // Jumps ahead by overriding the code register during the first settle.
    task automatic test_bit_order;
        exp_q.delete();
        push_code(12'd0, 12);
        start = 1'b1;
        cycles(50);
        force dut.TRIM_CODE = 12'hA52;
        cycles(1);
        release dut.TRIM_CODE;
        push_code(12'hA53, 12);
        cycles(3);
        total++; if (trim_code !== 12'hA53) begin bad++; $display("FAIL a53_code: got %h want a53", trim_code); end
        cycles(49);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL a53_bits: %0d bits not seen, want 0", exp_q.size()); end
        total++; if (trim_code !== 12'hA53) begin bad++; $display("FAIL a53_settle: got %h want a53", trim_code); end
        start = 1'b0;
        cycles(2);
        total++; if (trim_code !== 12'd0) begin bad++; $display("FAIL a53_stop: got %0d want 0", trim_code); end
    endtask

    task automatic test_sweep_end;
        int viol;
        exp_q.delete();
        push_code(12'd0, 12);
        start = 1'b1;
        cycles(50);
        force dut.TRIM_CODE = 12'd4093;
        cycles(1);
        release dut.TRIM_CODE;
        push_code(12'd4094, 12);
        push_code(12'd4095, 12);
        cycles(3);
        total++; if (trim_code !== 12'd4094) begin bad++; $display("FAIL end_code4094: got %0d want 4094", trim_code); end
        cycles(53);
        total++; if (trim_code !== 12'd4095) begin bad++; $display("FAIL end_code4095: got %0d want 4095", trim_code); end
        cycles(53);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL end_bits: %0d bits not seen, want 0", exp_q.size()); end
        viol = 0;
        repeat (100) begin
            cycles(1);
            if (trim_code !== 12'd4095 || enclk !== 1'b0 || dout !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL done_hold: %0d bad cycles, want 0", viol); end
        start = 1'b0;
        cycles(1);
        total++; if (trim_code !== 12'd0) begin bad++; $display("FAIL done_exit: got %0d want 0", trim_code); end
        cycles(2);
    endtask

    task automatic test_abort;
        exp_q.delete();
        for (int c = 0; c < 7; c++) push_code(12'(c), 12);
        push_code(12'd7, 6);
        start = 1'b1;
        cycles(395);
        total++; if (enclk !== 1'b1) begin bad++; $display("FAIL abort_pre_enclk: got %b want 1", enclk); end
        total++; if (trim_code !== 12'd7) begin bad++; $display("FAIL abort_pre_code: got %0d want 7", trim_code); end
        start = 1'b0;
        cycles(1);
        total++; if (enclk !== 1'b0 || dout !== 1'b0) begin bad++; $display("FAIL abort_lines: enclk=%b dout=%b want 0 0", enclk, dout); end
        total++; if (trim_code !== 12'd0) begin bad++; $display("FAIL abort_code: got %0d want 0", trim_code); end
        cycles(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_bits: %0d bits left, want 0", exp_q.size()); end
        push_code(12'd0, 12);
        start = 1'b1;
        cycles(54);
        total++; if (trim_code !== 12'd1) begin bad++; $display("FAIL restart_code: got %0d want 1", trim_code); end
        start = 1'b0;
        cycles(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_bits: %0d bits left, want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset;
        exp_q.delete();
        push_code(12'd0, 12);
        push_code(12'd1, 12);
        start = 1'b1;
        cycles(101);
        total++; if (enclk !== 1'b1 || dout !== 1'b1 || trim_code !== 12'd1) begin
            bad++; $display("FAIL areset_pre: enclk=%b dout=%b code=%0d want 1 1 1", enclk, dout, trim_code);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (enclk !== 1'b0 || dout !== 1'b0 || trim_code !== 12'd0) begin
            bad++; $display("FAIL areset_now: enclk=%b dout=%b code=%0d want 0 0 0", enclk, dout, trim_code);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL areset_bits: %0d bits left, want 0", exp_q.size()); end
        cycles(2);
        rst = 1'b0;
        push_code(12'd0, 12);
        cycles(54);
        total++; if (trim_code !== 12'd1) begin bad++; $display("FAIL areset_restart: got %0d want 1", trim_code); end
        start = 1'b0;
        cycles(2);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL areset_rbits: %0d bits left, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_bit_order();
        test_sweep_end();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
